// File: rtl/e203_exu_alu_oitf.sv
// Outstanding-instruction FIFO for in-order ALU write-back; optional macro E203_ALU_OITF_DEP_CHK_EN.
// Latency: alloc/retire visible next cycle, no bypass; backpressure: dis_ready=0 when full, retire-while-empty ignored.
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 1
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
`define E203_PC_SIZE 32
`endif

module e203_exu_alu_oitf (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dis_ena,
  output logic                         dis_ready,
  output logic [`E203_ITAG_WIDTH-1:0]  dis_ptr,
  input  logic [`E203_RFIDX_WIDTH-1:0] dis_rdidx,
  input  logic                         dis_rdwen,
  input  logic [`E203_PC_SIZE-1:0]     dis_pc,
  input  logic                         dis_rs1en,
  input  logic                         dis_rs2en,
  input  logic [`E203_RFIDX_WIDTH-1:0] dis_rs1idx,
  input  logic [`E203_RFIDX_WIDTH-1:0] dis_rs2idx,
  output logic                         oitf_raw_dep,
  output logic                         oitf_waw_dep,
  input  logic                         oitf_ret_ena,
  output logic [`E203_ITAG_WIDTH-1:0]  oitf_ret_ptr,
  output logic [`E203_RFIDX_WIDTH-1:0] oitf_ret_rdidx,
  output logic                         oitf_ret_rdwen,
  output logic [`E203_PC_SIZE-1:0]     oitf_ret_pc,
  output logic                         oitf_empty
);

  localparam int AW    = `E203_ITAG_WIDTH;
  localparam int RW    = `E203_RFIDX_WIDTH;
  localparam int PW    = `E203_PC_SIZE;
  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] r_alc_ptr;
  logic          r_alc_wrap;
  logic [AW-1:0] r_ret_ptr;
  logic          r_ret_wrap;
  logic          r_vld   [DEPTH];
  logic [RW-1:0] r_rdidx [DEPTH];
  logic          r_rdwen [DEPTH];
  logic [PW-1:0] r_pc    [DEPTH];

  logic w_ptr_eq;
  logic w_full;
  logic w_alloc;
  logic w_ret;

  assign w_ptr_eq   = (r_alc_ptr == r_ret_ptr);
  assign oitf_empty = w_ptr_eq & (r_alc_wrap == r_ret_wrap);
  assign w_full     = w_ptr_eq & (r_alc_wrap != r_ret_wrap);
  assign dis_ready  = ~w_full;
  assign w_alloc    = dis_ena & dis_ready;
  assign w_ret      = oitf_ret_ena & ~oitf_empty;

  assign dis_ptr        = r_alc_ptr;
  assign oitf_ret_ptr   = r_ret_ptr;
  assign oitf_ret_rdidx = r_rdidx[r_ret_ptr];
  assign oitf_ret_rdwen = r_rdwen[r_ret_ptr];
  assign oitf_ret_pc    = r_pc[r_ret_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alc_ptr  <= '0;
      r_alc_wrap <= 1'b0;
      r_ret_ptr  <= '0;
      r_ret_wrap <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]   <= 1'b0;
        r_rdidx[i] <= '0;
        r_rdwen[i] <= 1'b0;
        r_pc[i]    <= '0;
      end
    end else begin
      // Alloc and retire never hit the same slot in one cycle: that needs full, which blocks alloc.
      if (w_alloc) begin
        r_vld[r_alc_ptr]   <= 1'b1;
        r_rdidx[r_alc_ptr] <= dis_rdidx;
        r_rdwen[r_alc_ptr] <= dis_rdwen;
        r_pc[r_alc_ptr]    <= dis_pc;
        r_alc_ptr          <= r_alc_ptr + 1'b1;
        if (r_alc_ptr == AW'(DEPTH - 1)) r_alc_wrap <= ~r_alc_wrap;
      end
      if (w_ret) begin
        r_vld[r_ret_ptr] <= 1'b0;
        r_ret_ptr        <= r_ret_ptr + 1'b1;
        if (r_ret_ptr == AW'(DEPTH - 1)) r_ret_wrap <= ~r_ret_wrap;
      end
    end
  end

`ifdef E203_ALU_OITF_DEP_CHK_EN
  always_comb begin
    oitf_raw_dep = 1'b0;
    oitf_waw_dep = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] & r_rdwen[i]) begin
        if ((dis_rs1en & (r_rdidx[i] == dis_rs1idx)) |
            (dis_rs2en & (r_rdidx[i] == dis_rs2idx)))
          oitf_raw_dep = 1'b1;
        if (dis_rdwen & (r_rdidx[i] == dis_rdidx))
          oitf_waw_dep = 1'b1;
      end
    end
  end
`else
  // Without comparators any in-flight instruction is treated as a hazard.
  logic w_unused_dep_in;
  assign w_unused_dep_in = ^{dis_rs1en, dis_rs2en, dis_rs1idx, dis_rs2idx};
  assign oitf_raw_dep    = ~oitf_empty;
  assign oitf_waw_dep    = ~oitf_empty;
`endif

endmodule

// File: tb/tb_e203_exu_alu_oitf.sv
// Directed bench for e203_exu_alu_oitf (DEPTH=2); dep-flag expectations follow E203_ALU_OITF_DEP_CHK_EN.
`timescale 1ns/1ps
module tb_e203_exu_alu_oitf;

`ifdef E203_ALU_OITF_DEP_CHK_EN
  localparam bit DEP = 1'b1;
`else
  localparam bit DEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dis_ena;
  logic        dis_ready;
  logic [`E203_ITAG_WIDTH-1:0]  dis_ptr;
  logic [`E203_RFIDX_WIDTH-1:0] dis_rdidx;
  logic        dis_rdwen;
  logic [`E203_PC_SIZE-1:0]     dis_pc;
  logic        dis_rs1en, dis_rs2en;
  logic [`E203_RFIDX_WIDTH-1:0] dis_rs1idx, dis_rs2idx;
  logic        oitf_raw_dep, oitf_waw_dep;
  logic        oitf_ret_ena;
  logic [`E203_ITAG_WIDTH-1:0]  oitf_ret_ptr;
  logic [`E203_RFIDX_WIDTH-1:0] oitf_ret_rdidx;
  logic        oitf_ret_rdwen;
  logic [`E203_PC_SIZE-1:0]     oitf_ret_pc;
  logic        oitf_empty;

  int n_vec = 0;
  int n_err = 0;

  e203_exu_alu_oitf dut (
    .clk(clk), .rst_n(rst_n),
    .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
    .dis_rdidx(dis_rdidx), .dis_rdwen(dis_rdwen), .dis_pc(dis_pc),
    .dis_rs1en(dis_rs1en), .dis_rs2en(dis_rs2en),
    .dis_rs1idx(dis_rs1idx), .dis_rs2idx(dis_rs2idx),
    .oitf_raw_dep(oitf_raw_dep), .oitf_waw_dep(oitf_waw_dep),
    .oitf_ret_ena(oitf_ret_ena), .oitf_ret_ptr(oitf_ret_ptr),
    .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_ret_rdwen(oitf_ret_rdwen),
    .oitf_ret_pc(oitf_ret_pc), .oitf_empty(oitf_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; dis_ena = 1'b0; dis_rdidx = '0; dis_rdwen = 1'b0; dis_pc = '0;
    dis_rs1en = 1'b0; dis_rs2en = 1'b0; dis_rs1idx = '0; dis_rs2idx = '0; oitf_ret_ena = 1'b0;
    #12;
    chk("rst_empty", 64'(oitf_empty), 64'd1);
    chk("rst_ready", 64'(dis_ready), 64'd1);
    chk("rst_dis_ptr", 64'(dis_ptr), 64'd0);
    chk("rst_ret_ptr", 64'(oitf_ret_ptr), 64'd0);
    chk("rst_ret_rdidx", 64'(oitf_ret_rdidx), 64'd0);
    chk("rst_ret_rdwen", 64'(oitf_ret_rdwen), 64'd0);
    chk("rst_ret_pc", 64'(oitf_ret_pc), 64'd0);
    chk("rst_raw", 64'(oitf_raw_dep), 64'd0);
    chk("rst_waw", 64'(oitf_waw_dep), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_empty", 64'(oitf_empty), 64'd1);

    // Fill: rd5@0x100 then rd6@0x104
    dis_ena = 1'b1; dis_rdidx = 5'd5; dis_rdwen = 1'b1; dis_pc = 32'h100;
    tick();
    chk("fill1_dis_ptr", 64'(dis_ptr), 64'd1);
    chk("fill1_empty", 64'(oitf_empty), 64'd0);
    chk("fill1_ret_rdidx", 64'(oitf_ret_rdidx), 64'd5);
    chk("fill1_ready", 64'(dis_ready), 64'd1);
    dis_rdidx = 5'd6; dis_pc = 32'h104;
    tick();
    chk("full_ready", 64'(dis_ready), 64'd0);
    chk("full_ret_ptr", 64'(oitf_ret_ptr), 64'd0);
    chk("full_ret_rdidx", 64'(oitf_ret_rdidx), 64'd5);
    chk("full_ret_pc", 64'(oitf_ret_pc), 64'h100);
    dis_rdidx = 5'd9; dis_pc = 32'h200;
    tick();
    chk("blocked_ready", 64'(dis_ready), 64'd0);
    chk("blocked_dis_ptr", 64'(dis_ptr), 64'd0);
    chk("blocked_ret_pc", 64'(oitf_ret_pc), 64'h100);
    dis_ena = 1'b0;

    // Retire twice
    oitf_ret_ena = 1'b1;
    tick();
    chk("ret1_pc", 64'(oitf_ret_pc), 64'h104);
    chk("ret1_ptr", 64'(oitf_ret_ptr), 64'd1);
    chk("ret1_ready", 64'(dis_ready), 64'd1);
    tick();
    chk("ret2_empty", 64'(oitf_empty), 64'd1);
    chk("ret2_ret_ptr", 64'(oitf_ret_ptr), 64'd0);
    tick();
    chk("ret_empty_ignored_ptr", 64'(oitf_ret_ptr), 64'd0);
    chk("ret_empty_ignored_empty", 64'(oitf_empty), 64'd1);
    chk("ret_empty_ignored_ready", 64'(dis_ready), 64'd1);
    oitf_ret_ena = 1'b0;

    // Alloc after wrap: rd5@0x300 into itag 0
    chk("wrap_dis_ptr", 64'(dis_ptr), 64'd0);
    dis_ena = 1'b1; dis_rdidx = 5'd5; dis_rdwen = 1'b1; dis_pc = 32'h300;
    #1;
    chk("no_comb_alloc_empty", 64'(oitf_empty), 64'd1);
    tick();
    dis_ena = 1'b0; dis_rdwen = 1'b0; dis_rdidx = 5'd0;
    #1;
    chk("wrap_alloc_empty", 64'(oitf_empty), 64'd0);
    chk("wrap_alloc_pc", 64'(oitf_ret_pc), 64'h300);
    chk("wrap_alloc_dis_ptr", 64'(dis_ptr), 64'd1);

    // Dependency flags against rd5, rdwen=1
    dis_rs2en = 1'b1; dis_rs2idx = 5'd5;
    #1;
    chk("raw_rs2_hit", 64'(oitf_raw_dep), 64'd1);
    chk("waw_idle", 64'(oitf_waw_dep), DEP ? 64'd0 : 64'd1);
    dis_rs2en = 1'b0; dis_rs1en = 1'b1; dis_rs1idx = 5'd4;
    #1;
    chk("raw_rs1_miss", 64'(oitf_raw_dep), DEP ? 64'd0 : 64'd1);
    dis_rs1en = 1'b0; dis_rdwen = 1'b1; dis_rdidx = 5'd5;
    #1;
    chk("waw_hit", 64'(oitf_waw_dep), 64'd1);
    chk("raw_none", 64'(oitf_raw_dep), DEP ? 64'd0 : 64'd1);
    dis_rdwen = 1'b0;
    #1;
    chk("waw_no_rdwen", 64'(oitf_waw_dep), DEP ? 64'd0 : 64'd1);

    // Simultaneous alloc rd7@0x400 and retire of rd5
    dis_ena = 1'b1; dis_rdidx = 5'd7; dis_rdwen = 1'b1; dis_pc = 32'h400; oitf_ret_ena = 1'b1;
    tick();
    dis_ena = 1'b0; oitf_ret_ena = 1'b0;
    chk("sim_empty", 64'(oitf_empty), 64'd0);
    chk("sim_ret_rdidx", 64'(oitf_ret_rdidx), 64'd7);
    chk("sim_ret_pc", 64'(oitf_ret_pc), 64'h400);
    chk("sim_ret_ptr", 64'(oitf_ret_ptr), 64'd1);
    chk("sim_dis_ptr", 64'(dis_ptr), 64'd0);
    chk("sim_ready", 64'(dis_ready), 64'd1);

    // Replace with an rdwen=0 entry (rd3): no hazards when checking
    dis_ena = 1'b1; dis_rdidx = 5'd3; dis_rdwen = 1'b0; dis_pc = 32'h404; oitf_ret_ena = 1'b1;
    tick();
    dis_ena = 1'b0; oitf_ret_ena = 1'b0;
    dis_rs1en = 1'b1; dis_rs1idx = 5'd3; dis_rdwen = 1'b1; dis_rdidx = 5'd3;
    #1;
    chk("nowen_ret_rdwen", 64'(oitf_ret_rdwen), 64'd0);
    chk("nowen_ret_rdidx", 64'(oitf_ret_rdidx), 64'd3);
    chk("nowen_raw", 64'(oitf_raw_dep), DEP ? 64'd0 : 64'd1);
    chk("nowen_waw", 64'(oitf_waw_dep), DEP ? 64'd0 : 64'd1);

    // Fill again, then asynchronous reset mid-cycle
    dis_ena = 1'b1; dis_rdidx = 5'd8; dis_rdwen = 1'b1; dis_pc = 32'h500;
    tick();
    dis_ena = 1'b0;
    chk("refill_ready", 64'(dis_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 64'(oitf_empty), 64'd1);
    chk("arst_ready", 64'(dis_ready), 64'd1);
    chk("arst_dis_ptr", 64'(dis_ptr), 64'd0);
    chk("arst_ret_pc", 64'(oitf_ret_pc), 64'd0);
    chk("arst_raw", 64'(oitf_raw_dep), 64'd0);
    chk("arst_waw", 64'(oitf_waw_dep), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    oitf_ret_ena = 1'b1;
    tick();
    oitf_ret_ena = 1'b0;
    chk("post_rst_ret_ptr", 64'(oitf_ret_ptr), 64'd0);
    chk("post_rst_empty", 64'(oitf_empty), 64'd1);
    chk("post_rst_dis_ptr", 64'(dis_ptr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/e203_exu_alu_oitf.md
# e203_exu_alu_oitf

Outstanding-instruction tracking FIFO for ALU write-back ordering. Each dispatched ALU instruction allocates one entry and receives an itag, and entries retire strictly in dispatch order. The block sits directly upstream of the ALU write-back stage. It supplies that stage with the oldest entry's itag, rd index, rd write-enable and PC, plus an empty flag, and accepts that stage's retire strobe. It also gives dispatch RAW/WAW hazard flags against all in-flight entries.

## Interface
- DEPTH, 2, number of entries; must equal 2**`E203_ITAG_WIDTH (power of two, ≥2).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dis_ena  input  1  allocate entry this cycle; honoured only when dis_ready=1.
- dis_ready  output  1  FIFO not full.
- dis_ptr  output  `E203_ITAG_WIDTH  itag assigned to the entry allocated by dis_ena.
- dis_rdidx  input  `E203_RFIDX_WIDTH  destination register of the dispatching instruction.
- dis_rdwen  input  1  dispatching instruction writes rd.
- dis_pc  input  `E203_PC_SIZE  PC of the dispatching instruction.
- dis_rs1en, dis_rs2en  input  1 each  source operand used.
- dis_rs1idx, dis_rs2idx  input  `E203_RFIDX_WIDTH each  source register indices.
- oitf_raw_dep  output  1  dispatching sources depend on an in-flight rd.
- oitf_waw_dep  output  1  dispatching rd matches an in-flight rd.
- oitf_ret_ena  input  1  retire the oldest entry (from write-back stage).
- oitf_ret_ptr  output  `E203_ITAG_WIDTH  itag of the oldest entry.
- oitf_ret_rdidx  output  `E203_RFIDX_WIDTH  rd index of the oldest entry.
- oitf_ret_rdwen  output  1  rd write-enable of the oldest entry.
- oitf_ret_pc  output  `E203_PC_SIZE  PC of the oldest entry.
- oitf_empty  output  1  no valid entries.

## Operation
- State:
  - Alloc pointer and retire pointer, each `E203_ITAG_WIDTH bits plus a 1-bit wrap flag.
  - Per entry: vld, rdidx, rdwen, pc.
- alloc = dis_ena & dis_ready.
  - Writes {rdidx, rdwen, pc} into entry[alc_ptr] and sets its vld.
  - Advances alc_ptr. On wrap from DEPTH-1 to 0, toggles the alloc wrap flag.
- ret = oitf_ret_ena & ~oitf_empty.
  - Clears entry[ret_ptr].vld.
  - Advances ret_ptr, with the same wrap rule.
- oitf_empty = (alc_ptr == ret_ptr) & (wrap flags equal).
- full = (alc_ptr == ret_ptr) & (wrap flags differ); dis_ready = ~full.
- dis_ptr = alc_ptr; oitf_ret_ptr = ret_ptr; oitf_ret_{rdidx, rdwen, pc} = entry[ret_ptr] fields. All are combinational from registers.
- Dependency checks are made against every entry with vld=1:
  - raw: vld & rdwen & ((dis_rs1en & rdidx==dis_rs1idx) | (dis_rs2en & rdidx==dis_rs2idx)).
  - waw: vld & rdwen & dis_rdwen & rdidx==dis_rdidx.
  - The flags are the OR over all entries and are purely combinational.
- Boundary conditions:
  - alloc and ret in the same cycle: both pointers advance and the occupancy count is unchanged. Allowed in any non-empty state. When full, alloc is blocked by dis_ready=0.
  - ret when empty: ignored, no state change.
  - dis_ena with dis_ready=0: ignored; dis_ptr is unchanged.
  - An entry retiring in the current cycle still contributes to the dep flags (conservative).
  - x0 is not special-cased; dispatch drives rdwen=0 for x0.
- Reset:
  - All pointers and wrap flags go to 0; all vld go to 0; all entry fields go to 0.
  - Outputs after reset: oitf_empty=1, dis_ready=1, dis_ptr=0, oitf_ret_ptr=0, oitf_ret_rdidx=0, oitf_ret_rdwen=0, oitf_ret_pc=0, oitf_raw_dep=0, oitf_waw_dep=0.
  - Reset asserted mid-operation discards all entries immediately (asynchronous).

## Timing
- Allocation is visible one cycle later: after an alloc in cycle N, oitf_empty, dep flags and ret fields reflect the new entry in N+1.
- Retirement takes effect one cycle later: after a ret in cycle N, the next-oldest entry appears on oitf_ret_* in N+1.
- Same-cycle alloc into an empty FIFO does not appear on oitf_ret_* until N+1. There is no bypass.
- No combinational path from dis_ena to any output. No combinational path from oitf_ret_ena to any output.
- Combinational paths exist from dis_rs*/dis_rdidx/dis_rdwen to the dep flags only.

## Configuration
- Macro: E203_ALU_OITF_DEP_CHK_EN.
- Defined: per-entry RAW/WAW comparison as specified above.
- Undefined: the comparators are removed, and oitf_raw_dep = oitf_waw_dep = ~oitf_empty. Any in-flight instruction then stalls a dispatch that depends on the dep flags.

## Test plan
- Reset, then idle.
  - Required: oitf_empty=1, dis_ready=1, dis_ptr=0, dep flags 0.
- DEPTH=2 fill: alloc rd=5 pc=0x100, then alloc rd=6 pc=0x104.
  - Required: dis_ready=0 after the second alloc; oitf_ret_ptr=0, rdidx=5, pc=0x100.
  - A third dis_ena is ignored.
- Retire twice, then alloc again.
  - Required: oitf_ret_pc goes 0x100 → 0x104 → empty.
  - The next alloc gets dis_ptr=0 with the wrap flag toggled; oitf_empty=0 one cycle after.
- Simultaneous alloc (rd=7) and ret with one entry (rd=5) in flight.
  - Required: oitf_empty stays 0; next-cycle oitf_ret_rdidx=7; occupancy stays 1.
- With entry rd=5, rdwen=1 in flight:
  - dis_rs2en=1, rs2idx=5 → oitf_raw_dep=1.
  - dis_rdwen=1, rdidx=5 → oitf_waw_dep=1.
  - rs1idx=4 → raw=0.
  - Entry rdwen=0 → both flags 0.
  - With the macro undefined, both flags equal 1 whenever the FIFO is non-empty.
- With the FIFO full, assert rst_n low mid-cycle.
  - Required: oitf_empty=1 and dis_ready=1 immediately; oitf_ret_ena while empty causes no pointer change.
